uart_rx: RTL

Receive half of the AXI4-Lite UART. Oversamples the asynchronous `i_uart_rx` line with a 16x strobe from the shared baud generator and deserialises 5–8 data bits with optional parity and 1 or 2 stop bits. Received bytes go into an internal FIFO that the register block drains. Parity, framing and overflow errors are reported as sticky flags, and a fill-level threshold flag drives the RX interrupt.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_if.sv | 43 ++++
 rtl/sync_fifo_with_clear.sv | 69 ++++++
 rtl/uart_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: receiver/transmitter state set and the
// fill-threshold code mapping used by the RX interrupt.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP0,
    STOP1
  } uart_state_t;

  // Code 0 means one byte; codes 1..7 mean twice the code.
  function automatic logic [4:0] thr_bytes(input logic [2:0] code);
    thr_bytes = (code == 3'd0) ? 5'd1 : {1'b0, code, 1'b0};
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// UART RX register-block bus: FIFO drain, status,
// threshold and sticky error flags.
interface uart_rx_if;
  logic [2:0] i_threshold_value;
  logic       o_threshold;
  logic       i_fifo_rd_en;
  logic [7:0] o_fifo_rd_data;
  logic       i_fifo_clear;
  logic       o_fifo_full;
  logic       o_fifo_empty;
  logic       i_error_clear;
  logic       o_overflow_error;
  logic       o_parity_error;
  logic       o_frame_error;

  modport master (
    output i_threshold_value,
    output i_fifo_rd_en,
    output i_fifo_clear,
    output i_error_clear,
    input  o_threshold,
    input  o_fifo_rd_data,
    input  o_fifo_full,
    input  o_fifo_empty,
    input  o_overflow_error,
    input  o_parity_error,
    input  o_frame_error
  );

  modport slave (
    input  i_threshold_value,
    input  i_fifo_rd_en,
    input  i_fifo_clear,
    input  i_error_clear,
    output o_threshold,
    output o_fifo_rd_data,
    output o_fifo_full,
    output o_fifo_empty,
    output o_overflow_error,
    output o_parity_error,
    output o_frame_error
  );
endinterface

// File: rtl/sync_fifo_with_clear.sv
// Single-clock FIFO with synchronous flush and an optional
// second read-data register.
module sync_fifo_with_clear #(
  parameter int DATA_WIDTH            = 8,
  parameter int DEPTH                 = 16,
  parameter int EXTRA_OUTPUT_REGISTER = 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= '0;
    else if (rd_ok) rd_q <= mem[rd_ptr];
  end

  generate
    if (EXTRA_OUTPUT_REGISTER != 0) begin : g_xreg
      always_ff @(posedge clk) begin
        if (!rst_n) rd_data <= '0;
        else rd_data <= rd_q;
      end
    end else begin : g_noreg
      assign rd_data = rd_q;
    end
  endgenerate

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deserialiser feeding an RX FIFO,
// with sticky error flags and a fill-level threshold.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_parity,
  input  logic [1:0] i_data_bits,
  input  logic       i_stop_bits,
  input  logic       i_use_parity,
  input  logic       i_rx_strb,
  output logic       o_rx_strb_en,
  input  logic       i_uart_rx,
  uart_rx_if.slave   bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        rx_m;
  logic        rx_s;
  uart_state_t state;
  logic [3:0]  tick;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  sh_next;
  logic        par_acc;
  logic [1:0]  cfg_bits;
  logic        cfg_par_en;
  logic        cfg_stop2;
  logic        par_pend;
  logic        frm_pend;
  logic        done;
  logic        mid_bit;
  logic        end_bit;
  logic [2:0]  last_bit;
  logic [CW-1:0] fill;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_uart_rx;
      rx_s <= rx_m;
    end
  end

  assign mid_bit  = i_rx_strb && (tick == 4'd7);
  assign end_bit  = i_rx_strb && (tick == 4'd15);
  assign last_bit = 3'd4 + {1'b0, cfg_bits};
  assign sh_next  = {rx_s, shreg[7:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      o_rx_strb_en <= 1'b0;
      tick         <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      cfg_bits     <= '0;
      cfg_par_en   <= 1'b0;
      cfg_stop2    <= 1'b0;
      par_pend     <= 1'b0;
      frm_pend     <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (i_rx_strb) tick <= tick + 4'd1;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state        <= START;
            o_rx_strb_en <= 1'b1;
            tick         <= '0;
            bit_cnt      <= '0;
            cfg_bits     <= i_data_bits;
            cfg_par_en   <= i_use_parity;
            cfg_stop2    <= i_stop_bits;
            par_acc      <= i_parity;
            par_pend     <= 1'b0;
            frm_pend     <= 1'b0;
          end
        end
        START: begin
          if (mid_bit) begin
            tick    <= '0;
            bit_cnt <= '0;
            if (rx_s) begin
              state        <= IDLE;
              o_rx_strb_en <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (end_bit) begin
            shreg   <= sh_next;
            par_acc <= par_acc ^ rx_s;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == last_bit) begin
              // Short words arrive in the top bits; right-justify them.
              shreg   <= sh_next >> (2'd3 - cfg_bits);
              tick    <= '0;
              bit_cnt <= '0;
              state   <= cfg_par_en ? PARITY : STOP0;
            end
          end
        end
        PARITY: begin
          if (end_bit) begin
            par_pend <= (rx_s != par_acc);
            tick     <= '0;
            bit_cnt  <= '0;
            state    <= STOP0;
          end
        end
        STOP0: begin
          if (end_bit) begin
            if (!rx_s) frm_pend <= 1'b1;
            tick    <= '0;
            bit_cnt <= '0;
            if (cfg_stop2) begin
              state <= STOP1;
            end else begin
              state        <= IDLE;
              o_rx_strb_en <= 1'b0;
              done         <= 1'b1;
            end
          end
        end
        STOP1: begin
          if (end_bit) begin
            if (!rx_s) frm_pend <= 1'b1;
            tick         <= '0;
            bit_cnt      <= '0;
            state        <= IDLE;
            o_rx_strb_en <= 1'b0;
            done         <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          o_rx_strb_en <= 1'b0;
        end
      endcase
    end
  end

  // A flag set in the same cycle as a clear must survive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.o_overflow_error <= 1'b0;
      bus.o_parity_error   <= 1'b0;
      bus.o_frame_error    <= 1'b0;
    end else begin
      if (bus.i_error_clear) begin
        bus.o_overflow_error <= 1'b0;
        bus.o_parity_error   <= 1'b0;
        bus.o_frame_error    <= 1'b0;
      end
      if (done) begin
        if (bus.o_fifo_full) bus.o_overflow_error <= 1'b1;
        if (par_pend)        bus.o_parity_error   <= 1'b1;
        if (frm_pend)        bus.o_frame_error    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bus.o_threshold <= 1'b0;
    else bus.o_threshold <=
      32'(fill) >= 32'(thr_bytes(bus.i_threshold_value));
  end

  sync_fifo_with_clear #(
    .DATA_WIDTH            (8),
    .DEPTH                 (FIFO_DEPTH),
    .EXTRA_OUTPUT_REGISTER (1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.i_fifo_clear),
    .wr_en   (done),
    .wr_data (shreg),
    .rd_en   (bus.i_fifo_rd_en),
    .rd_data (bus.o_fifo_rd_data),
    .full    (bus.o_fifo_full),
    .empty   (bus.o_fifo_empty),
    .count   (fill)
  );

endmodule
